alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter-free ports; widths come from config.v: `RS_TYPE_BIT (5), `ROB_SIZE_BIT.
REQ-002 SHALL have port clk_in, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port rdy_in, input, 1, global enable; when low, all state holds.
REQ-005 SHALL have port rob_clear, input, 1, pipeline flush from ROB (mispredict).
REQ-006 SHALL have port alu_valid, input, 1, issue strobe from reservation station; no backpressure exists.
REQ-007 SHALL have port alu_r1 / alu_r2, input, 32 each, resolved operands.
REQ-008 SHALL have port alu_op, input, `RS_TYPE_BIT, operation code.
REQ-009 SHALL have port alu_rob_idx, input, `ROB_SIZE_BIT, destination ROB entry.
REQ-010 SHALL have port alu_wb_valid, output, 1, result broadcast strobe to ROB and RS.
REQ-011 SHALL have port alu_wb_idx, output, `ROB_SIZE_BIT, ROB index of broadcast result.
REQ-012 SHALL have port alu_wb_value, output, 32, result value.

Function
REQ-013 SHALL accept an op in every cycle with alu_valid=1 and rdy_in=1, without stall or drop.
REQ-014 SHALL decode alu_op as: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
REQ-015 SHALL use only alu_r2[4:0] as shift amount; SRA is arithmetic.
REQ-016 SHALL wrap ADD/SUB modulo 2^32; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-017 SHALL produce 32'd1 (condition true) or 32'd0 (false) for SLT/SLTU and all branch ops.
REQ-018 SHALL produce 32'd0 for any undefined alu_op code; the result is still broadcast.
REQ-019 SHALL have a fixed latency L (1 without the Configuration macro, 2 with it): an op accepted at edge t drives alu_wb_valid=1 with its idx/value for exactly the cycle after edge t+L-1.
REQ-020 SHALL complete results strictly in issue order, one per cycle maximum; there is never a writeback collision.
REQ-021 SHALL drive alu_wb_valid=0 in every cycle with no completing op; alu_wb_idx/value are don't-care then but SHALL hold last values.
REQ-022 SHALL, when rdy_in=0, freeze all pipeline stages and outputs; an op presented during that cycle is ignored.
REQ-023 SHALL, on rob_clear=1 at an edge, invalidate every in-flight stage, including an op issued that same cycle; alu_wb_valid=0 the next cycle.
REQ-024 SHALL give rob_clear precedence over rdy_in=0.

Reset
REQ-025 SHALL, on rst_in=1 at an edge, clear all stage valid bits, alu_wb_valid=0, alu_wb_idx=0, alu_wb_value=0.
REQ-026 SHALL discard an op issued in the reset cycle; the first accepted op is in the cycle after rst_in falls.
REQ-027 SHALL give rst_in precedence over rob_clear and rdy_in.

Configuration
REQ-028 SHALL, with macro ALU_MUL_EN defined, add codes 16 MUL (low 32), 17 MULH (s*s high), 18 MULHSU (s*u high), 19 MULHU (u*u high).
REQ-029 SHALL, with ALU_MUL_EN defined, split execution into two registered stages (partial products / final sum), with L=2 for all ops, including base ops.
REQ-030 SHALL, without ALU_MUL_EN, have L=1 with a single result register; codes 16-19 are undefined and yield 0 per REQ-018.

Verification
REQ-031 SHALL pass: ADD r1=0xFFFFFFFF r2=1 idx=3 -> after L cycles alu_wb_valid=1, idx=3, value=0x00000000.
REQ-032 SHALL pass: back-to-back SRA(0x80000000,36) idx1, BLTU(1,0xFFFFFFFF) idx2, XOR(0xF0,0xFF) idx3 -> three consecutive writebacks: 0xF8000000, 1, 0x0F in order.
REQ-033 SHALL pass: op SUB(5,7) idx4 issued, rdy_in low 3 cycles -> output frozen; writeback of 0xFFFFFFFE appears L cycles of rdy_in high after issue.
REQ-034 SHALL pass: ops at idx5 and idx6 in flight plus idx7 issued with rob_clear=1 -> no writeback for idx5/6/7; an op issued the next cycle writes back normally.
REQ-035 SHALL pass: with ALU_MUL_EN, MULH(0xFFFFFFFF,0xFFFFFFFF)=0, MULHU(same)=0xFFFFFFFE, MULHSU(0xFFFFFFFF,2)=0xFFFFFFFF, MUL(0x10000,0x10000)=0, each at latency 2; without the macro, each yields 0 at latency 1.
REQ-036 SHALL pass: rst_in asserted with an op in flight -> alu_wb_valid=0, idx=0, value=0 next cycle; no stale writeback ever appears.

Source files
------------

// File: rtl/alu_exec.sv
// Integer execution unit: fixed-latency ALU/branch-compare writing back to ROB/RS in issue order.
// Build macro ALU_MUL_EN adds MUL/MULH/MULHSU/MULHU and a two-stage pipeline (latency 2 for every op).
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module alu_exec (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,
    input  logic                     alu_valid,
    input  logic [31:0]              alu_r1,
    input  logic [31:0]              alu_r2,
    input  logic [`RS_TYPE_BIT-1:0]  alu_op,
    input  logic [`ROB_SIZE_BIT-1:0] alu_rob_idx,
    output logic                     alu_wb_valid,
    output logic [`ROB_SIZE_BIT-1:0] alu_wb_idx,
    output logic [31:0]              alu_wb_value
);

    typedef enum logic [`RS_TYPE_BIT-1:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
    } op_e;

    logic [4:0]  shamt;
    logic [31:0] base_res;

    assign shamt = alu_r2[4:0];

    always_comb begin
        base_res = '0;
        case (op_e'(alu_op))
            OP_ADD:  base_res = alu_r1 + alu_r2;
            OP_SUB:  base_res = alu_r1 - alu_r2;
            OP_SLL:  base_res = alu_r1 << shamt;
            OP_SLT:  base_res = {31'b0, $signed(alu_r1) < $signed(alu_r2)};
            OP_SLTU: base_res = {31'b0, alu_r1 < alu_r2};
            OP_XOR:  base_res = alu_r1 ^ alu_r2;
            OP_SRL:  base_res = alu_r1 >> shamt;
            OP_SRA:  base_res = $unsigned($signed(alu_r1) >>> shamt);
            OP_OR:   base_res = alu_r1 | alu_r2;
            OP_AND:  base_res = alu_r1 & alu_r2;
            OP_BEQ:  base_res = {31'b0, alu_r1 == alu_r2};
            OP_BNE:  base_res = {31'b0, alu_r1 != alu_r2};
            OP_BLT:  base_res = {31'b0, $signed(alu_r1) < $signed(alu_r2)};
            OP_BGE:  base_res = {31'b0, $signed(alu_r1) >= $signed(alu_r2)};
            OP_BLTU: base_res = {31'b0, alu_r1 < alu_r2};
            OP_BGEU: base_res = {31'b0, alu_r1 >= alu_r2};
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    // Stage 1 keeps four 16x16 partial products plus the signed-high correction term.
    logic                     s1_valid;
    logic [`ROB_SIZE_BIT-1:0] s1_idx;
    logic [1:0]               s1_kind;
    logic [31:0]              s1_base;
    logic [31:0]              s1_pp0, s1_pp1, s1_pp2, s1_pp3;
    logic [31:0]              s1_corr;

    logic [1:0]  kind;
    logic [31:0] corr;
    logic [63:0] prod;
    logic [31:0] prod_hi;
    logic [31:0] s2_res;

    always_comb begin
        kind = 2'd0;
        corr = '0;
        case (op_e'(alu_op))
            OP_MUL:    kind = 2'd1;
            OP_MULH: begin
                kind = 2'd2;
                corr = (alu_r1[31] ? alu_r2 : 32'd0) + (alu_r2[31] ? alu_r1 : 32'd0);
            end
            OP_MULHSU: begin
                kind = 2'd2;
                corr = alu_r1[31] ? alu_r2 : 32'd0;
            end
            OP_MULHU:  kind = 2'd2;
            default:   kind = 2'd0;
        endcase
    end

    // Signed high words are the unsigned high word minus the sign corrections, mod 2^32.
    always_comb begin
        prod    = {32'b0, s1_pp0} + ({32'b0, s1_pp1} << 16) + ({32'b0, s1_pp2} << 16)
                + {s1_pp3, 32'b0};
        prod_hi = prod[63:32] - s1_corr;
        case (s1_kind)
            2'd1:    s2_res = prod[31:0];
            2'd2:    s2_res = prod_hi;
            default: s2_res = s1_base;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid     <= 1'b0;
            alu_wb_valid <= 1'b0;
            alu_wb_idx   <= '0;
            alu_wb_value <= '0;
        end else if (rob_clear) begin
            s1_valid     <= 1'b0;
            alu_wb_valid <= 1'b0;
        end else if (rdy_in) begin
            s1_valid     <= alu_valid;
            alu_wb_valid <= s1_valid;
            if (alu_valid) begin
                s1_idx  <= alu_rob_idx;
                s1_kind <= kind;
                s1_base <= base_res;
                s1_pp0  <= {16'b0, alu_r1[15:0]}  * {16'b0, alu_r2[15:0]};
                s1_pp1  <= {16'b0, alu_r1[31:16]} * {16'b0, alu_r2[15:0]};
                s1_pp2  <= {16'b0, alu_r1[15:0]}  * {16'b0, alu_r2[31:16]};
                s1_pp3  <= {16'b0, alu_r1[31:16]} * {16'b0, alu_r2[31:16]};
                s1_corr <= corr;
            end
            if (s1_valid) begin
                alu_wb_idx   <= s1_idx;
                alu_wb_value <= s2_res;
            end
        end
    end
`else
    // Idx/value only load on a real completion so they hold between writebacks.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_wb_valid <= 1'b0;
            alu_wb_idx   <= '0;
            alu_wb_value <= '0;
        end else if (rob_clear) begin
            alu_wb_valid <= 1'b0;
        end else if (rdy_in) begin
            alu_wb_valid <= alu_valid;
            if (alu_valid) begin
                alu_wb_idx   <= alu_rob_idx;
                alu_wb_value <= base_res;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed results, checked every cycle against an in-order expectation queue.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module tb_alu_exec;

`ifdef ALU_MUL_EN
    localparam int L = 2;
    localparam logic [31:0] E_MUL_BIG = 32'h0000_0000;
    localparam logic [31:0] E_MULH    = 32'h0000_0000;
    localparam logic [31:0] E_MULHU   = 32'hFFFF_FFFE;
    localparam logic [31:0] E_MULHSU  = 32'hFFFF_FFFF;
    localparam logic [31:0] E_MUL_76  = 32'd42;
`else
    localparam int L = 1;
    localparam logic [31:0] E_MUL_BIG = 32'h0;
    localparam logic [31:0] E_MULH    = 32'h0;
    localparam logic [31:0] E_MULHU   = 32'h0;
    localparam logic [31:0] E_MULHSU  = 32'h0;
    localparam logic [31:0] E_MUL_76  = 32'h0;
`endif

    logic                     clk_in = 1'b0;
    logic                     rst_in, rdy_in, rob_clear, alu_valid;
    logic [31:0]              alu_r1, alu_r2;
    logic [`RS_TYPE_BIT-1:0]  alu_op;
    logic [`ROB_SIZE_BIT-1:0] alu_rob_idx;
    logic                     alu_wb_valid;
    logic [`ROB_SIZE_BIT-1:0] alu_wb_idx;
    logic [31:0]              alu_wb_value;

    alu_exec dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op(alu_op),
        .alu_rob_idx(alu_rob_idx), .alu_wb_valid(alu_wb_valid),
        .alu_wb_idx(alu_wb_idx), .alu_wb_value(alu_wb_value)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int                       due;
        logic [`ROB_SIZE_BIT-1:0] idx;
        logic [31:0]              val;
    } ent_t;

    ent_t  q[$];
    int    total = 0;
    int    bad = 0;
    int    act = 0;
    string step = "init";
    logic [31:0] pend_val;
    logic                     ev;
    logic [`ROB_SIZE_BIT-1:0] ei;
    logic [31:0]              ed;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s/%s: observed=%h expected=%h", step, name, obs, exp);
        end
    endtask

    // One clock edge; inputs are held from the previous falling edge, outputs sampled on the next.
    task automatic tick();
        ent_t e;
        @(negedge clk_in);
        if (rst_in) begin
            q.delete();
            ev = 1'b0; ei = '0; ed = '0;
        end else if (rob_clear) begin
            q.delete();
            ev = 1'b0;
        end else if (rdy_in) begin
            act++;
            if (alu_valid) begin
                e.due = act + L - 1;
                e.idx = alu_rob_idx;
                e.val = pend_val;
                q.push_back(e);
            end
            ev = 1'b0;
            if (q.size() > 0 && q[0].due == act) begin
                ev = 1'b1;
                ei = q[0].idx;
                ed = q[0].val;
                void'(q.pop_front());
            end
        end
        chk("wb_valid", {31'b0, alu_wb_valid}, {31'b0, ev});
        chk("wb_idx", 32'(alu_wb_idx), 32'(ei));
        chk("wb_value", alu_wb_value, ed);
    endtask

    task automatic issue(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                         input int idx, input logic [31:0] expv);
        step        = tag;
        alu_valid   = 1'b1;
        alu_op      = `RS_TYPE_BIT'(op);
        alu_r1      = a;
        alu_r2      = b;
        alu_rob_idx = `ROB_SIZE_BIT'(idx);
        pend_val    = expv;
        tick();
        alu_valid   = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        step = tag;
        repeat (n) tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
        alu_valid = 1'b1; alu_op = '0; alu_r1 = 32'd1; alu_r2 = 32'd1;
        alu_rob_idx = `ROB_SIZE_BIT'(9); pend_val = '0;
        ev = 1'b0; ei = '0; ed = '0;

        // Op presented during reset must be discarded.
        idle("reset", 2);
        rst_in = 1'b0;
        alu_valid = 1'b0;

        issue("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 3, 32'h0);
        idle("add_wrap_drain", L + 1);

        issue("b2b_sra",  7,  32'h8000_0000, 32'd36, 1, 32'hF800_0000);
        issue("b2b_bltu", 14, 32'd1, 32'hFFFF_FFFF, 2, 32'd1);
        issue("b2b_xor",  5,  32'h0000_00F0, 32'h0000_00FF, 3, 32'h0000_000F);
        idle("b2b_drain", L + 1);

        issue("sub",  1,  32'd5, 32'd7, 5, 32'hFFFF_FFFE);
        issue("sll",  2,  32'd1, 32'h21, 6, 32'd2);
        issue("slt",  3,  32'hFFFF_FFFF, 32'd1, 7, 32'd1);
        issue("sltu", 4,  32'hFFFF_FFFF, 32'd1, 8, 32'd0);
        issue("srl",  6,  32'h8000_0000, 32'd4, 9, 32'h0800_0000);
        issue("or",   8,  32'h0000_00F0, 32'h0000_000F, 10, 32'h0000_00FF);
        issue("and",  9,  32'h0000_F0F0, 32'h0000_0FF0, 11, 32'h0000_00F0);
        issue("beq",  10, 32'd5, 32'd5, 12, 32'd1);
        issue("bne",  11, 32'd5, 32'd5, 13, 32'd0);
        issue("blt",  12, 32'd1, 32'hFFFF_FFFF, 14, 32'd0);
        issue("bge",  13, 32'h8000_0000, 32'd0, 15, 32'd0);
        issue("bgeu", 15, 32'h8000_0000, 32'd0, 0, 32'd1);
        issue("undef20", 20, 32'h1234_5678, 32'h1, 1, 32'd0);
        issue("undef31", 31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'd0);
        idle("alu_drain", L + 1);

        issue("mulh",   17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, E_MULH);
        issue("mulhu",  19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, E_MULHU);
        issue("mulhsu", 18, 32'hFFFF_FFFF, 32'd2, 5, E_MULHSU);
        issue("mul_big", 16, 32'h0001_0000, 32'h0001_0000, 6, E_MUL_BIG);
        issue("mul_small", 16, 32'd7, 32'd6, 7, E_MUL_76);
        idle("mul_drain", L + 1);

        // Stall: outputs freeze and ops shown while stalled are ignored.
        issue("stall_sub", 1, 32'd5, 32'd7, 4, 32'hFFFF_FFFE);
        rdy_in = 1'b0;
        issue("stall_ign0", 0, 32'd1, 32'd1, 9, 32'd2);
        issue("stall_ign1", 0, 32'd1, 32'd1, 9, 32'd2);
        issue("stall_ign2", 0, 32'd1, 32'd1, 9, 32'd2);
        rdy_in = 1'b1;
        idle("stall_resume", L + 1);

        // Flush kills in-flight ops and one issued in the flush cycle.
        issue("flush_a", 0, 32'd10, 32'd1, 5, 32'd11);
        issue("flush_b", 0, 32'd20, 32'd1, 6, 32'd21);
        rob_clear = 1'b1;
        issue("flush_c", 0, 32'd30, 32'd1, 7, 32'd31);
        rob_clear = 1'b0;
        issue("flush_after", 0, 32'd40, 32'd2, 8, 32'd42);
        idle("flush_drain", L + 1);

        // Flush wins over a stall.
        issue("clr_stall_op", 9, 32'hFF, 32'h0F, 10, 32'h0F);
        rdy_in = 1'b0; rob_clear = 1'b1;
        idle("clr_stall", 1);
        rdy_in = 1'b1; rob_clear = 1'b0;
        idle("clr_stall_drain", L + 1);

        // Reset with ops in flight: cleared outputs, nothing stale afterwards.
        issue("rst_fl_a", 0, 32'd3, 32'd4, 11, 32'd7);
        rst_in = 1'b1; rob_clear = 1'b1; rdy_in = 1'b0;
        issue("rst_fl_b", 0, 32'd5, 32'd6, 12, 32'd11);
        rst_in = 1'b0; rob_clear = 1'b0; rdy_in = 1'b1;
        idle("rst_after", L + 1);
        issue("post_rst", 5, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 13, 32'h5555_5555);
        idle("post_rst_drain", L + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
